// File: rtl/flux_demux.sv
`default_nettype none
// ============================================================================
//  Module      : flux_demux
//  Description : Tag-directed demultiplexer. Pops {tag, data} tokens from a
//                first-word-fall-through FIFO and steers each into a small
//                per-flux circular buffer. Each buffer drains independently
//                into its own downstream FIFO. Saturating per-flux delivery
//                counters and a drop counter (out-of-range tags) are exposed.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                in_empty/in_dout/in_read    - upstream FIFO read side
//                out_full/out_din/out_write  - per-flux downstream write sides
//                tok_cnt, drop_cnt           - debug statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module flux_demux #(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 16,
    localparam int TAG_WIDTH = $clog2(FLUX),
    localparam int IN_WIDTH  = DATA_WIDTH + TAG_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_empty,
    input  logic [IN_WIDTH-1:0]             in_dout,
    output logic                            in_read,
    input  logic [FLUX-1:0]                 out_full,
    output logic [FLUX*DATA_WIDTH-1:0]      out_din,
    output logic [FLUX-1:0]                 out_write,
    output logic [FLUX*CNT_WIDTH-1:0]       tok_cnt,
    output logic [CNT_WIDTH-1:0]            drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [TAG_WIDTH:0]   c_FLUX    = (TAG_WIDTH+1)'(FLUX);
    localparam logic [OCC_W-1:0]     c_DEPTH   = OCC_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    logic [TAG_WIDTH-1:0]  w_tag;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_tag_ok;
    logic [FLUX-1:0]       w_hit;
    logic [FLUX-1:0]       w_full;
    logic                  w_blocked;
    logic                  w_drop;
    logic [CNT_WIDTH-1:0]  r_drop;

    assign w_tag    = in_dout[IN_WIDTH-1 -: TAG_WIDTH];
    assign w_data   = in_dout[DATA_WIDTH-1:0];
    // Zero-extend so the compare is meaningful for power-of-two FLUX as well.
    assign w_tag_ok = ({1'b0, w_tag} < c_FLUX);

    // Head-of-line: the head only waits on its own flux's buffer; downstream
    // full flags never reach in_read.
    assign w_blocked = |(w_hit & w_full);
    assign in_read   = !rst && !in_empty && (!w_tag_ok || !w_blocked);
    assign w_drop    = in_read && !w_tag_ok;
    assign drop_cnt  = r_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != c_CNT_MAX)) begin
            r_drop <= r_drop + CNT_WIDTH'(1);
        end
    end

    for (genvar j = 0; j < FLUX; j++) begin : g_flux
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]      r_wptr;
        logic [PTR_W-1:0]      r_rptr;
        logic [OCC_W-1:0]      r_occ;
        logic [CNT_WIDTH-1:0]  r_tok;
        logic                  w_push;
        logic                  w_pop;
        logic                  w_nonempty;

        assign w_hit[j]    = (w_tag == TAG_WIDTH'(j));
        assign w_full[j]   = (r_occ == c_DEPTH);
        assign w_nonempty  = (r_occ != '0);
        assign w_push      = in_read && w_tag_ok && w_hit[j];
        assign w_pop       = !rst && w_nonempty && !out_full[j];

        assign out_write[j] = w_pop;
        assign out_din[j*DATA_WIDTH +: DATA_WIDTH] =
            (!rst && w_nonempty) ? r_mem[r_rptr] : '0;
        assign tok_cnt[j*CNT_WIDTH +: CNT_WIDTH] = r_tok;

        // Storage needs no reset; occupancy decides what is valid.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= w_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_occ  <= '0;
                r_tok  <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                    if (r_tok != c_CNT_MAX) begin
                        r_tok <= r_tok + CNT_WIDTH'(1);
                    end
                end
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + OCC_W'(1);
                    2'b01:   r_occ <= r_occ - OCC_W'(1);
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flux_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flux_demux
//  Description : Directed self-checking bench for flux_demux. Instance u_a uses
//                the default 2-flux configuration; instance u_b uses three
//                fluxes and 4-bit counters for out-of-range tags and counter
//                saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flux_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance A: FLUX=2, DEPTH=2, DATA_WIDTH=8, CNT_WIDTH=16
    logic        a_empty = 1'b1;
    logic [8:0]  a_dout  = '0;
    logic        a_read;
    logic [1:0]  a_full  = '0;
    logic [15:0] a_din;
    logic [1:0]  a_write;
    logic [31:0] a_tok;
    logic [15:0] a_drop;

    // Instance B: FLUX=3, DEPTH=2, DATA_WIDTH=8, CNT_WIDTH=4
    logic        b_empty = 1'b1;
    logic [9:0]  b_dout  = '0;
    logic        b_read;
    logic [2:0]  b_full  = '0;
    logic [23:0] b_din;
    logic [2:0]  b_write;
    logic [11:0] b_tok;
    logic [3:0]  b_drop;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    flux_demux u_a (
        .clk       (clk),
        .rst       (rst),
        .in_empty  (a_empty),
        .in_dout   (a_dout),
        .in_read   (a_read),
        .out_full  (a_full),
        .out_din   (a_din),
        .out_write (a_write),
        .tok_cnt   (a_tok),
        .drop_cnt  (a_drop)
    );

    flux_demux #(
        .DATA_WIDTH (8),
        .FLUX       (3),
        .DEPTH      (2),
        .CNT_WIDTH  (4)
    ) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_empty  (b_empty),
        .in_dout   (b_dout),
        .in_read   (b_read),
        .out_full  (b_full),
        .out_din   (b_din),
        .out_write (b_write),
        .tok_cnt   (b_tok),
        .drop_cnt  (b_drop)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; observations made after
    // the call describe the cycle that ends at the next rising edge.
    task automatic drive_a(input logic r, input logic e, input logic t,
                           input logic [7:0] d, input logic [1:0] f);
        @(negedge clk);
        rst     = r;
        a_empty = e;
        a_dout  = {t, d};
        a_full  = f;
        #1;
    endtask

    task automatic drive_b(input logic e, input logic [1:0] t,
                           input logic [7:0] d, input logic [2:0] f);
        @(negedge clk);
        b_empty = e;
        b_dout  = {t, d};
        b_full  = f;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rnd;
        logic [7:0] q[$];

        // ---------------- reset / idle ----------------
        drive_a(1'b1, 1'b1, 1'b0, 8'h00, 2'b00);
        check("rst_read", a_read, 1'b0);
        check("rst_write", a_write, 2'b00);
        check("rst_din", a_din, 16'h0000);
        drive_a(1'b1, 1'b0, 1'b1, 8'hEE, 2'b00);
        check("rst_read_nonempty", a_read, 1'b0);
        check("rst_write2", a_write, 2'b00);
        check("rst_din2", a_din, 16'h0000);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("idle_tok", a_tok, 32'h0);
        check("idle_drop", a_drop, 16'h0);
        check("idle_write", a_write, 2'b00);
        check("b_idle_tok", b_tok, 12'h0);

        // ---------------- basic steering ----------------
        drive_a(1'b0, 1'b0, 1'b1, 8'h5A, 2'b00);
        check("basic_read1", a_read, 1'b1);
        check("basic_nowrite", a_write, 2'b00);
        drive_a(1'b0, 1'b0, 1'b0, 8'h33, 2'b00);
        check("basic_read0", a_read, 1'b1);
        check("basic_write1", a_write, 2'b10);
        check("basic_din1", a_din[15:8], 8'h5A);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("basic_write0", a_write, 2'b01);
        check("basic_din0", a_din[7:0], 8'h33);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("basic_quiet", a_write, 2'b00);
        check("basic_tok", a_tok, {16'd1, 16'd1});

        // ---------------- backpressure / fill ----------------
        drive_a(1'b0, 1'b0, 1'b0, 8'hA1, 2'b01);
        check("bp_acc1", a_read, 1'b1);
        drive_a(1'b0, 1'b0, 1'b0, 8'hA2, 2'b01);
        check("bp_acc2", a_read, 1'b1);
        check("bp_held", a_write, 2'b00);
        drive_a(1'b0, 1'b0, 1'b0, 8'hA3, 2'b01);
        check("bp_stall", a_read, 1'b0);
        check("bp_head_visible", a_din[7:0], 8'hA1);
        drive_a(1'b0, 1'b0, 1'b0, 8'hA3, 2'b00);
        check("bp_rel_stall", a_read, 1'b0);
        check("bp_rel_write", a_write, 2'b01);
        check("bp_rel_din", a_din[7:0], 8'hA1);
        drive_a(1'b0, 1'b0, 1'b0, 8'hA3, 2'b00);
        check("bp_third_acc", a_read, 1'b1);
        check("bp_din2", a_din[7:0], 8'hA2);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("bp_write3", a_write, 2'b01);
        check("bp_din3", a_din[7:0], 8'hA3);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("bp_done", a_write, 2'b00);
        check("bp_tok", a_tok, {16'd1, 16'd4});

        // ---------------- cross-flux isolation ----------------
        drive_a(1'b0, 1'b0, 1'b0, 8'hB1, 2'b11);
        drive_a(1'b0, 1'b0, 1'b1, 8'hC1, 2'b11);
        drive_a(1'b0, 1'b0, 1'b0, 8'hB2, 2'b11);
        drive_a(1'b0, 1'b0, 1'b1, 8'hC2, 2'b11);
        check("xf_fill_acc", a_read, 1'b1);
        drive_a(1'b0, 1'b0, 1'b0, 8'hB3, 2'b01);
        check("xf_hol_stall1", a_read, 1'b0);
        check("xf_drain1_wr", a_write, 2'b10);
        check("xf_drain1_din", a_din[15:8], 8'hC1);
        drive_a(1'b0, 1'b0, 1'b0, 8'hB3, 2'b01);
        check("xf_hol_stall2", a_read, 1'b0);
        check("xf_drain2_din", a_din[15:8], 8'hC2);
        check("xf_drain2_wr", a_write, 2'b10);
        drive_a(1'b0, 1'b0, 1'b0, 8'hB3, 2'b01);
        check("xf_hol_stall3", a_read, 1'b0);
        check("xf_f1_empty", a_write, 2'b00);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("xf_f0_b1", a_din[7:0], 8'hB1);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("xf_f0_b2", a_din[7:0], 8'hB2);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("xf_tok", a_tok, {16'd3, 16'd6});

        // ---------------- simultaneous accept + drain, 100 tokens ----------------
        for (int i = 0; i < 100; i++) begin
            rnd = 8'($urandom_range(0, 255));
            drive_a(1'b0, 1'b0, 1'b0, rnd, 2'b00);
            check("cont_read", a_read, 1'b1);
            check("cont_write", a_write, (i > 0) ? 2'b01 : 2'b00);
            if (i > 0) begin
                check("cont_din", a_din[7:0], q.pop_front());
            end
            q.push_back(rnd);
        end
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("cont_last_wr", a_write, 2'b01);
        check("cont_last_din", a_din[7:0], q.pop_front());
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("cont_idle", a_write, 2'b00);
        check("cont_tok", a_tok, {16'd3, 16'd106});

        // ---------------- mid-operation reset ----------------
        drive_a(1'b0, 1'b0, 1'b0, 8'hD1, 2'b11);
        drive_a(1'b0, 1'b0, 1'b1, 8'hE1, 2'b11);
        drive_a(1'b0, 1'b0, 1'b0, 8'hD2, 2'b11);
        drive_a(1'b0, 1'b0, 1'b1, 8'hE2, 2'b11);
        drive_a(1'b0, 1'b0, 1'b1, 8'hE3, 2'b11);
        check("mr_full_stall", a_read, 1'b0);
        check("mr_heads", a_din, {8'hE1, 8'hD1});
        drive_a(1'b1, 1'b0, 1'b0, 8'hD3, 2'b00);
        check("mr_rst_read", a_read, 1'b0);
        check("mr_rst_write", a_write, 2'b00);
        check("mr_rst_din", a_din, 16'h0000);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("mr_after_write", a_write, 2'b00);
        check("mr_after_din", a_din, 16'h0000);
        check("mr_after_tok", a_tok, 32'h0);
        drive_a(1'b0, 1'b0, 1'b1, 8'hF1, 2'b00);
        check("mr_new_read", a_read, 1'b1);
        drive_a(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        check("mr_new_write", a_write, 2'b10);
        check("mr_new_din", a_din[15:8], 8'hF1);

        // ---------------- out-of-range tag (FLUX = 3) ----------------
        drive_b(1'b0, 2'd3, 8'h77, 3'b000);
        check("oor_read", b_read, 1'b1);
        check("oor_nowrite", b_write, 3'b000);
        drive_b(1'b1, 2'd0, 8'h00, 3'b000);
        check("oor_nowrite2", b_write, 3'b000);
        check("oor_drop", b_drop, 4'd1);

        // ---------------- counter saturation (CNT_WIDTH = 4) ----------------
        for (int i = 0; i < 18; i++) begin
            drive_b(1'b0, 2'd2, 8'(i), 3'b000);
            check("sat_read", b_read, 1'b1);
        end
        drive_b(1'b1, 2'd0, 8'h00, 3'b000);
        check("sat_last_din", b_din[23:16], 8'd17);
        drive_b(1'b1, 2'd0, 8'h00, 3'b000);
        check("sat_tok2", b_tok[11:8], 4'd15);
        check("sat_tok10", b_tok[7:0], 8'h00);
        check("sat_drop_kept", b_drop, 4'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
